// File: rtl/uart_pkg.sv
// Constants shared by the UART transmit and receive paths.
package uart_pkg;
  localparam int DATA_WIDTH = 8;
endpackage

// File: rtl/uart_rx_if.sv
// Parallel output channel of the UART receiver: word, status flags, valid/ready.
interface uart_rx_if;
  import uart_pkg::*;

  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  parity_err;
  logic                  frame_err;

  modport master (output rx_data, rx_valid, parity_err, frame_err, input rx_ready);
  modport slave  (input rx_data, rx_valid, parity_err, frame_err, output rx_ready);
endinterface

// File: rtl/uart_rx.sv
// UART receiver, one bit per clk: start, LSB-first data, optional parity, stop bits.
// Completed frames land in a single-entry valid/ready register together with their status.
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   LINE_WAIT | line low after a framing error/reset; wait for rx=1
//   IDLE      | line high; next rx=0 sample is a start bit
//   DATA      | shifting DATA_WIDTH data bits, LSB first
//   PARITY    | sampling and checking the parity bit
//   STOP      | sampling STOP_BITS stop bits; last one completes the frame
module uart_rx
  import uart_pkg::*;
#(
  parameter int PARITY_EN = 0,
  parameter int STOP_BITS = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rx,
  uart_rx_if.master    bus,
  output logic         rx_overrun,
  output logic         rx_busy
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int SW = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;

  typedef enum logic [2:0] {
    LINE_WAIT = 3'd0,
    IDLE      = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [SW-1:0]         stop_cnt_q, stop_cnt_d;
  logic                  perr_q, perr_d;
  logic                  ferr_q, ferr_d;
  logic                  complete;
  logic                  exp_par;

  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  par_err_q;
  logic                  frm_err_q;
  logic                  ovr_q;
  logic                  busy_q;

  assign exp_par = (^sreg_q) ^ (PARITY_EN == 2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LINE_WAIT;
      sreg_q     <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    complete   = 1'b0;
    case (state_q)
      LINE_WAIT: begin
        if (rx) state_d = IDLE;
      end
      IDLE: begin
        if (!rx) begin
          state_d   = DATA;
          bit_cnt_d = '0;
          perr_d    = 1'b0;
          ferr_d    = 1'b0;
        end
      end
      DATA: begin
        sreg_d    = (sreg_q >> 1) | (DATA_WIDTH'(rx) << (DATA_WIDTH - 1));
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == BW'(DATA_WIDTH - 1)) begin
          if (PARITY_EN != 0) begin
            state_d = PARITY;
          end else begin
            state_d    = STOP;
            stop_cnt_d = '0;
          end
        end
      end
      PARITY: begin
        perr_d     = (rx != exp_par);
        state_d    = STOP;
        stop_cnt_d = '0;
      end
      STOP: begin
        ferr_d     = ferr_q | ~rx;
        stop_cnt_d = stop_cnt_q + 1'b1;
        if (stop_cnt_q == SW'(STOP_BITS - 1)) begin
          complete = 1'b1;
          // A low final stop bit may be the start of a break; wait for the line to recover.
          state_d  = rx ? IDLE : LINE_WAIT;
        end
      end
      default: state_d = LINE_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      ovr_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      ovr_q  <= 1'b0;
      busy_q <= (state_d != IDLE) && (state_d != LINE_WAIT);
      if (complete) begin
        if (!valid_q || bus.rx_ready) begin
          data_q    <= sreg_q;
          par_err_q <= (PARITY_EN != 0) && perr_q;
          frm_err_q <= ferr_d;
          valid_q   <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (valid_q && bus.rx_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.rx_data    = data_q;
  assign bus.rx_valid   = valid_q;
  assign bus.parity_err = par_err_q;
  assign bus.frame_err  = frm_err_q;
  assign rx_overrun     = ovr_q;
  assign rx_busy        = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: six instances covering PARITY_EN 0..2 x STOP_BITS 1..2.
// Config index c: PARITY_EN = c/2, STOP_BITS = c%2 + 1.
module tb_uart_rx;
  localparam int NCFG = 6;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } frame_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_l   [NCFG];
  logic rdy    [NCFG];
  logic comp_f [NCFG];
  logic busy_f [NCFG];
  logic done = 1'b0;

  frame_t sb_q [$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cfg%0d: got %0h expected %0h at %0t", nm, c, act, exp, $time);
    end
  endtask

  for (genvar c = 0; c < NCFG; c++) begin : g
    uart_rx_if bus ();
    logic   ovr, busy;
    bit     mvalid, ovr_exp, busy_exp, acc, dropped;
    frame_t hold, e;
    int     drops = 0;
    int     ovrs  = 0;

    assign bus.rx_ready = rdy[c];

    uart_rx #(.PARITY_EN(c / 2), .STOP_BITS(c % 2 + 1)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx         (rx_l[c]),
      .bus        (bus),
      .rx_overrun (ovr),
      .rx_busy    (busy)
    );

    // Model predicts the effect of the coming edge; results are checked one negedge later.
    always @(negedge clk) begin
      if (!rst_n) begin
        chk("rst_data", c, 32'(bus.rx_data), 32'h0);
        chk("rst_valid", c, 32'(bus.rx_valid), 32'h0);
        chk("rst_perr", c, 32'(bus.parity_err), 32'h0);
        chk("rst_ferr", c, 32'(bus.frame_err), 32'h0);
        chk("rst_ovr", c, 32'(ovr), 32'h0);
        chk("rst_busy", c, 32'(busy), 32'h0);
        mvalid   = 1'b0;
        ovr_exp  = 1'b0;
        busy_exp = 1'b0;
      end else begin
        chk("valid", c, 32'(bus.rx_valid), 32'(mvalid));
        chk("overrun", c, 32'(ovr), 32'(ovr_exp));
        chk("busy", c, 32'(busy), 32'(busy_exp));
        if (ovr) ovrs++;
        acc = mvalid && rdy[c];
        if (acc) begin
          chk("data", c, 32'(bus.rx_data), 32'(hold.data));
          chk("parity_err", c, 32'(bus.parity_err), 32'(hold.perr));
          chk("frame_err", c, 32'(bus.frame_err), 32'(hold.ferr));
        end
        dropped = 1'b0;
        if (comp_f[c]) begin
          if (sb_q.size() == 0) begin
            chk("sb_empty", c, 32'h1, 32'h0);
          end else begin
            e = sb_q.pop_front();
            if (!mvalid || rdy[c]) begin
              hold   = e;
              mvalid = 1'b1;
            end else begin
              dropped = 1'b1;
              drops++;
            end
          end
        end else if (acc) begin
          mvalid = 1'b0;
        end
        ovr_exp  = dropped;
        busy_exp = busy_f[c];
      end
    end

    initial begin
      wait (done);
      chk("drops_vs_overrun", c, 32'(ovrs), 32'(drops));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int c, input logic b, input logic bz, input logic cp, input logic r);
    for (int j = 0; j < NCFG; j++) begin
      rx_l[j]   = 1'b1;
      comp_f[j] = 1'b0;
      busy_f[j] = 1'b0;
      rdy[j]    = 1'b1;
    end
    rx_l[c]   = b;
    busy_f[c] = bz;
    comp_f[c] = cp;
    rdy[c]    = r;
  endtask

  task automatic idle(input int c, input int n, input logic lvl, input logic r);
    for (int i = 0; i < n; i++) begin
      tick();
      drive(c, lvl, 1'b0, 1'b0, r);
    end
  endtask

  // rmode: 0 ready low, 1 ready high, 2 random ready, 3 ready only on the completion cycle
  task automatic send(input int c, input logic [7:0] d, input logic par_bit,
                      input logic last_stop0, input logic exp_perr, input int rmode);
    int   pe, s, n;
    logic b, last, r;
    frame_t f;
    pe = c / 2;
    s  = c % 2 + 1;
    n  = 1 + 8 + ((pe != 0) ? 1 : 0) + s;
    f.data = d;
    f.perr = exp_perr;
    f.ferr = last_stop0;
    sb_q.push_back(f);
    for (int i = 0; i < n; i++) begin
      last = (i == n - 1);
      if (i == 0)                 b = 1'b0;
      else if (i <= 8)            b = d[i-1];
      else if (pe != 0 && i == 9) b = par_bit;
      else                        b = last ? ~last_stop0 : 1'b1;
      case (rmode)
        0:       r = 1'b0;
        1:       r = 1'b1;
        2:       r = 1'($urandom_range(0, 1));
        default: r = last;
      endcase
      tick();
      drive(c, b, ~last, last, r);
    end
  endtask

  initial begin
    logic [7:0] d, pd;
    logic       flip, ls0, pb;
    int         c, pe;
    for (int j = 0; j < NCFG; j++) begin
      rx_l[j] = 1'b1; rdy[j] = 1'b1; comp_f[j] = 1'b0; busy_f[j] = 1'b0;
    end
    repeat (3) tick();
    rst_n = 1'b1;
    idle(0, 2, 1'b1, 1'b1);

    // plain 8N1 word
    send(0, 8'hA5, 1'b0, 1'b0, 1'b0, 1);
    idle(0, 2, 1'b1, 1'b1);

    // even parity with a corrupted parity bit, then odd parity with the correct bit
    send(2, 8'h07, 1'b0, 1'b0, 1'b1, 1);
    idle(2, 2, 1'b1, 1'b1);
    send(4, 8'h07, 1'b0, 1'b0, 1'b0, 1);
    idle(4, 2, 1'b1, 1'b1);

    // second stop bit low, line held low, then recovery
    send(1, 8'h5A, 1'b0, 1'b1, 1'b0, 1);
    idle(1, 5, 1'b0, 1'b1);
    idle(1, 1, 1'b1, 1'b1);
    send(1, 8'h3C, 1'b0, 1'b0, 1'b0, 1);
    idle(1, 2, 1'b1, 1'b1);

    // back-pressure: second frame dropped, third accepted with ready on its completion edge
    send(0, 8'h11, 1'b0, 1'b0, 1'b0, 0);
    send(0, 8'h22, 1'b0, 1'b0, 1'b0, 0);
    send(0, 8'h33, 1'b0, 1'b0, 1'b0, 3);
    idle(0, 3, 1'b1, 1'b1);

    // reset in the middle of data bit 4
    pd = 8'h96;
    for (int i = 0; i < 5; i++) begin
      tick();
      drive(0, (i == 0) ? 1'b0 : pd[i-1], 1'b1, 1'b0, 1'b1);
    end
    tick();
    drive(0, pd[4], 1'b0, 1'b0, 1'b1);
    rst_n = 1'b0;
    idle(0, 2, 1'b1, 1'b1);
    tick();
    rst_n = 1'b1;
    drive(0, 1'b1, 1'b0, 1'b0, 1'b1);
    send(0, 8'hF0, 1'b0, 1'b0, 1'b0, 1);
    idle(0, 3, 1'b1, 1'b1);

    // random sweep: groups of 8 back-to-back frames per config with random ready
    for (int k = 0; k < 256; k++) begin
      c    = (k / 8) % NCFG;
      pe   = c / 2;
      d    = 8'($urandom);
      flip = 1'($urandom_range(0, 1));
      ls0  = ($urandom_range(0, 7) == 0);
      pb   = (^d) ^ (pe == 2) ^ flip;
      send(c, d, pb, ls0, flip && (pe != 0), 2);
      if (ls0) idle(c, 1, 1'b1, 1'($urandom_range(0, 1)));
      if (k % 8 == 7) idle(c, 2, 1'b1, 1'b1);
    end
    idle(0, 4, 1'b1, 1'b1);

    chk("sb_leftover", 0, 32'(sb_q.size()), 32'h0);
    done = 1'b1;
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver that deframes the bit stream produced by the team's UART transmitter: start bit, `DATA_WIDTH` data bits LSB first, optional parity bit, `STOP_BITS` stop bits, at one bit per `clk` cycle with no baud divider. It sits on the receive side of the UART loopback and peripheral path. It delivers each frame as a parallel word with parity and framing status through a single-entry valid/ready output register.

## Interface
- `PARITY_EN`, default 0: 0 = no parity bit; 1 = expected parity = XOR of data bits; 2 = expected parity = inverted XOR of data bits. These match the transmitter's encoding bit-for-bit.
- `STOP_BITS`, default 1: number of stop-bit cycles, ≥1.
- `DATA_WIDTH`: shared package constant, not a parameter.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: one clock; reset is asynchronous and active-low.
- `rx` in 1: serial line; idle high; same clock domain as the transmitter, so no synchronizer.
- `rx_data` out DATA_WIDTH: received word; valid while `rx_valid`=1.
- `rx_valid` out 1: output register holds an unread frame.
- `rx_ready` in 1: consumer accepts `rx_data` on any edge where `rx_valid && rx_ready`.
- `parity_err` out 1: the held frame's parity mismatched; always 0 when `PARITY_EN`=0.
- `frame_err` out 1: at least one stop bit of the held frame was sampled 0.
- `rx_overrun` out 1: one-cycle pulse when a completed frame is dropped.
- `rx_busy` out 1: FSM is not in IDLE or LINE_WAIT.

## Operation
- FSM states are LINE_WAIT, IDLE, DATA, PARITY and STOP. `rx` is sampled on every rising edge.
- **LINE_WAIT:** on `rx`=1 go to IDLE. While `rx`=0, stay here (line low/break; no start detection).
- **IDLE:** on `rx`=0, that sample is the start bit. Go to DATA with `bit_cnt`=0. On `rx`=1, stay.
- **DATA:** shift `rx` into the MSB of the shift register (right shift), so after `DATA_WIDTH` samples bit 0 is the first received bit. Increment `bit_cnt`.
- **DATA exit:** on the sample where `bit_cnt`==`DATA_WIDTH`-1, go to PARITY if `PARITY_EN`≠0, else go to STOP with `stop_cnt`=0.
- **PARITY:** capture `rx` and compare it with the expected parity of the shifted word. A mismatch sets the internal `perr` flag. Go to STOP.
- **STOP:** each sample ORs `~rx` into the internal `ferr` flag. Increment `stop_cnt`.
- **STOP exit:** on the sample where `stop_cnt`==`STOP_BITS`-1, complete the frame. Go to LINE_WAIT if the final stop sample was 0, else go to IDLE.
- **Frame completion:** if `rx_valid`=0, or `rx_ready`=1 on the same edge, load `rx_data`/`parity_err`/`frame_err` and set `rx_valid`=1.
- **Dropped frame:** otherwise keep the held word and error flags unchanged, drop the new frame, and pulse `rx_overrun` for exactly one cycle.
- **Accept without completion:** `rx_valid && rx_ready` with no completion on that edge clears `rx_valid`. `rx_data` and the error flags keep their last value.
- Frames with errors are still delivered; error flags travel with their word.
- **Reset (including mid-frame):** any partial frame is discarded and the FSM enters LINE_WAIT. All outputs go to 0, including `rx_data`, `rx_valid`, `parity_err`, `frame_err`, `rx_overrun` and `rx_busy`. Internal counters, shift register and flags clear.

## Timing
- One FSM step per edge; all outputs are registered.
- Let P = (`PARITY_EN`≠0) and S = `STOP_BITS`.
- The start bit is sampled at edge Es. Data bit k is sampled at Es+1+k, parity at Es+1+DATA_WIDTH, and stop bits at the following S edges.
- `rx_valid` rises after edge Es+DATA_WIDTH+P+S, the edge that samples the last stop bit.
- **Loopback with the transmitter:** when `tx_start` is sampled at edge E0, the start bit is sampled at E2. `rx_valid` rises on the same edge as `tx_done`, E(2+DATA_WIDTH+P+S).
- Back-to-back frames are fully supported. The transmitter's minimum inter-frame idle of ≥2 high cycles is not required; a start bit may be sampled on the edge right after the last stop bit.
- `rx_busy` is 1 from the edge after start detection through the last stop sample.

## Test plan
- DATA_WIDTH=8, `PARITY_EN`=0, S=1: loopback `tx_data`=8'hA5 with `rx_ready`=1 → `rx_valid` rises on the same edge as `tx_done` (E11), `rx_data`=8'hA5, both error flags 0.
- `PARITY_EN`=1: send 8'h07 with the parity bit forced to 0 instead of 1 → `parity_err`=1, `rx_data`=8'h07. Repeat with `PARITY_EN`=2 and correct parity 0 → `parity_err`=0.
- S=2: drive the second stop bit 0 → `frame_err`=1 and FSM enters LINE_WAIT. Hold `rx` low 5 cycles → no new frame. Raise `rx` for 1 cycle, then send 8'h3C → received cleanly.
- `rx_ready`=0: send 8'h11 then 8'h22 back-to-back → `rx_data` stays 8'h11 and `rx_overrun` pulses once. Set `rx_ready`=1 on the completion edge of a third frame 8'h33 → `rx_data`=8'h33, `rx_valid` stays 1, no overrun pulse.
- Assert `rst_n`=0 at data bit 4 of a frame → all outputs 0 immediately. After release, `rx` high 1 cycle then send 8'hF0 → exactly one frame delivered, 8'hF0.
- Sweep 256 random words with random `rx_ready` back-pressure and all `PARITY_EN`/S combos → scoreboard matches every non-dropped word, and dropped count equals `rx_overrun` pulse count.
